stream_mux_rr: RTL

Parametrised N-channel, W-bit stream multiplexer: successor to the fixed 2x1 combinational mux. It selects one of `N_CH` valid/ready input streams and forwards it through a single registered output stage. Selection is either round-robin arbitration or a forced select, and packets are optionally kept atomic.

---
 rtl/stream_mux_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/stream_mux_rr.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
package stream_mux_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    // A channel index needs at least one bit, even for two channels.
    function automatic int ch_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: the first requester after ptr wins.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = ch_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [CW-1:0] ptr,
    output logic [CW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [CW:0]   sum;
    logic [CW-1:0] idx;

    // The loop runs from the farthest offset down to the nearest, so the
    // last hit to be written is the closest requester after ptr.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = |req;
        sum     = '0;
        idx     = '0;
        for (int off = N; off >= 1; off--) begin
            sum = (CW+1)'(ptr) + (CW+1)'(off);
            if (sum >= (CW+1)'(N)) sum = sum - (CW+1)'(N);
            idx = sum[CW-1:0];
            if (req[idx]) gnt_idx = idx;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin or forced selection,
// optional packet locking, and a single registered output stage.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int DATA_W   = 8,
    parameter  bit LOCK_PKT = 1'b1,
    localparam int CH_W     = ch_w(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH-1:0]          in_last,
    output logic [N_CH-1:0]          in_ready,
    input  logic                     force_en,
    input  logic [CH_W-1:0]          force_sel,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    logic [N_CH-1:0][DATA_W-1:0] in_lanes;
    assign in_lanes = in_data;

    arb_state_t          state_q, state_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]     lock_ch_q, lock_ch_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic [CH_W-1:0]     out_ch_q, out_ch_d;

    logic [CH_W-1:0]     rr_gnt;
    logic                rr_vld;
    logic [CH_W-1:0]     grant;
    logic                grant_vld;
    logic                load_ok;
    logic                accept;
    logic                beat_last;

    rr_arbiter #(.N(N_CH)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (rr_gnt),
        .gnt_vld (rr_vld)
    );

    // rst_n gating keeps in_ready low while reset is held.
    assign load_ok = rst_n && (!out_valid_q || out_ready);

    always_comb begin
        grant     = rr_gnt;
        grant_vld = rr_vld;
        if (state_q == ARB_LOCKED) begin
            grant     = lock_ch_q;
            grant_vld = in_valid[lock_ch_q];
        end else if (force_en) begin
            grant     = force_sel;
            grant_vld = (int'(force_sel) < N_CH) && in_valid[force_sel];
        end
    end

    assign accept    = load_ok && grant_vld;
    assign beat_last = in_last[grant];

    for (genvar g = 0; g < N_CH; g++) begin : g_rdy
        assign in_ready[g] = accept && (grant == CH_W'(g));
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_ch_d   = lock_ch_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_ch_d    = out_ch_q;

        if (accept) begin
            out_data_d  = in_lanes[grant];
            out_valid_d = 1'b1;
            out_last_d  = beat_last;
            out_ch_d    = grant;
            // Pointer advances at packet end so the next packet rotates on.
            if (!LOCK_PKT || beat_last) rr_ptr_d = grant;
            if (LOCK_PKT) begin
                if (state_q == ARB_IDLE && !beat_last) begin
                    state_d   = ARB_LOCKED;
                    lock_ch_d = grant;
                end else if (state_q == ARB_LOCKED && beat_last) begin
                    state_d = ARB_IDLE;
                end
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= CH_W'(N_CH - 1);
            lock_ch_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_ch_q   <= lock_ch_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_ch    = out_ch_q;

endmodule
